// File: rtl/grant_if.sv
// Grant handshake between the request collector and its consumer.
// The collector drives valid/id; the consumer drives ready.
interface grant_if;
   logic       grant_valid;
   logic [3:0] grant_id;
   logic       grant_ready;

   modport master (
      output grant_valid,
      output grant_id,
      input  grant_ready
   );

   modport slave (
      input  grant_valid,
      input  grant_id,
      output grant_ready
   );
endinterface

// File: rtl/request_collector.sv
// Sticky 16-bit pending register wrapped around an external priority encoder.
// Offers one winning request ID at a time over a valid/ready handshake.
module request_collector #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       req_a,
   input  logic [7:0]       req_b,
   output logic [7:0]       pend_a,
   output logic [7:0]       pend_b,
   input  logic [3:0]       enc_address,
   input  logic             enc_valid,
   grant_if.master          grant,
   output logic [4:0]       pending_count,
   output logic [CNT_W-1:0] coalesced,
   output logic             enc_error
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OFFER = 1'b1;

   // Sum must hold the counter plus up to 16 hits without wrapping.
   localparam int unsigned SUM_W = ((CNT_W > 5) ? CNT_W : 5) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   logic [0:0]       state_q, state_d;
   logic [15:0]      p_q, p_d;
   logic [3:0]       grant_id_q, grant_id_d;
   logic [CNT_W-1:0] coalesced_q, coalesced_d;
   logic             enc_error_q, enc_error_d;

   logic [15:0]      req;
   logic [15:0]      clr_mask;
   logic             accept;
   logic [4:0]       hits;
   logic [4:0]       pop;
   logic [SUM_W-1:0] sum;

   // NOTE: every variable gets a default at the top of always_comb so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      req      = {req_a, req_b};
      accept   = (state_q == ST_OFFER) && grant.grant_ready;
      clr_mask = '0;
      if (accept) clr_mask[grant_id_q] = 1'b1;

      // A new request on the same edge as its clear wins, keeping the event.
      p_d = (p_q & ~clr_mask) | req;

      hits = '0;
      pop  = '0;
      for (int i = 0; i < 16; i++) begin
         hits = hits + 5'(req[i] & p_q[i] & ~clr_mask[i]);
         pop  = pop + 5'(p_q[i]);
      end

      sum         = SUM_W'(coalesced_q) + SUM_W'(hits);
      coalesced_d = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      enc_error_d = enc_error_q;
      case (state_q)
         ST_IDLE: begin
            if (enc_valid) begin
               if (p_q[enc_address]) begin
                  grant_id_d = enc_address;
                  state_d    = ST_OFFER;
               end else begin
                  enc_error_d = 1'b1;
               end
            end
         end
         ST_OFFER: begin
            if (accept) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         p_q         <= '0;
         grant_id_q  <= '0;
         coalesced_q <= '0;
         enc_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         p_q         <= p_d;
         grant_id_q  <= grant_id_d;
         coalesced_q <= coalesced_d;
         enc_error_q <= enc_error_d;
      end
   end

   assign pend_a            = p_q[15:8];
   assign pend_b            = p_q[7:0];
   assign pending_count     = pop;
   assign coalesced         = coalesced_q;
   assign enc_error         = enc_error_q;
   assign grant.grant_valid = (state_q == ST_OFFER);
   assign grant.grant_id    = grant_id_q;

endmodule

// File: doc/request_collector.md
Name: request_collector

Overview:
- Upstream/downstream wrapper around the 16-input priority encoder.
- Captures single-cycle request pulses into a sticky 16-bit pending register and drives that register onto the encoder's A/B inputs.
- Consumes the encoder's address/valid result and offers the winning request ID to a consumer over a valid/ready handshake.
- Clears each pending bit once its grant is accepted.

Parameters:
- CNT_W, 8, width of the saturating coalesced-event counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_a  input  8  request pulses, IDs 15..8 (req_a[7] = ID 15)
- req_b  input  8  request pulses, IDs 7..0 (req_b[0] = ID 0)
- pend_a  output  8  pending bits 15..8, to encoder A
- pend_b  output  8  pending bits 7..0, to encoder B
- enc_address  input  4  encoder result: index of highest set pending bit
- enc_valid  input  1  encoder result: any pending bit set
- grant_valid  output  1  grant offered
- grant_id  output  4  offered request ID
- grant_ready  input  1  consumer accepts grant
- pending_count  output  5  population count of pending register (0..16)
- coalesced  output  CNT_W  count of requests that hit an already-pending bit
- enc_error  output  1  sticky: encoder reported an ID whose pending bit is clear

Behaviour:
- Pending register P[15:0]:
  - pend_a = P[15:8], pend_b = P[7:0], driven directly from flops.
  - Encoder is combinational, so enc_* reflect P in the same cycle.
- Set/clear per bit i, each edge:
  - Set if {req_a,req_b}[i] = 1.
  - Clear if a grant for ID i is accepted this cycle.
  - Set and clear on the same edge: set wins, bit stays 1 (new event retained).
- Coalescing:
  - Request on a bit already 1 that is not being cleared this edge increments coalesced by 1 per such bit.
  - Multiple bits in one cycle add their total.
  - coalesced saturates at all-ones.
- FSM, 2 states:
  - IDLE: grant_valid = 0. If enc_valid = 1 and P[enc_address] = 1, latch grant_id <= enc_address and go to OFFER. If enc_valid = 1 and P[enc_address] = 0, set enc_error, stay in IDLE, issue no grant.
  - OFFER: grant_valid = 1, grant_id held stable, even if a higher-priority request arrives. On grant_ready = 1: clear P[grant_id] (subject to set-wins) and go to IDLE. Otherwise stay in OFFER.
- Throughput: at most one grant per 2 cycles. IDLE always re-samples the encoder after P has updated.
- Latency: request pulse at edge N sets P at N. With nothing else pending, grant_valid rises at edge N+1.
- grant_ready while in IDLE: ignored.
- enc_valid = 0 with P nonzero: no grant. enc_error is not set, because the consistency check applies only when enc_valid = 1.
- pending_count: combinational popcount of P.
- Reset (any time, including mid-OFFER): at the edge with rst = 1:
  - P = 0, state IDLE, grant_valid = 0, grant_id = 0, coalesced = 0, enc_error = 0.
  - Requests in the reset cycle are discarded.

Test Plan:
- Reset, then single pulse req_b = 8'h01 -> P = 16'h0001, pending_count = 1, next cycle grant_valid = 1, grant_id = 0. grant_ready = 1 -> P = 0, grant_valid = 0 the following cycle.
- Pulse req_a = 8'h80, req_b = 8'h04 together, grant_ready tied 1 -> grants in order ID 15 then ID 2, two cycles apart, then P = 0.
- Offer ID 3 with grant_ready = 0 for 5 cycles, pulse req_a = 8'h01 (ID 8) meanwhile -> grant_id stays 3 until accepted, then next grant is ID 8.
- Pulse req_b = 8'h10 twice while ID 4 is pending and not granted -> coalesced = 2. Pulse ID 4 on the same edge its grant is accepted -> P[4] stays 1, coalesced unchanged, second grant of ID 4 follows.
- Model the encoder returning enc_address = 5, enc_valid = 1 with P = 16'h0002 -> enc_error = 1 and sticky, no grant issued.
- Assert rst during OFFER with P = 16'hFFFF -> next cycle P = 0, grant_valid = 0, pending_count = 0, coalesced = 0.
